// File: rtl/fetch_pkg.sv
// Shared types for the fetch stage: instruction-bus payloads and the fetch->decode record.
// Pure type/constant definitions, no logic.
// Everything else in this slice imports from here.

package common;
  // Architectural boot address; the fetch block uses it as its default start PC.
  localparam logic [63:0] PC_RESET = 64'h0000_0000_8000_0000;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;
endpackage

package pipes;
  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [31:0] raw_instr;
  } fetch_data_t;
endpackage

// File: rtl/fetch_if.sv
// Instruction-bus connection between the fetch stage (master) and memory (slave).
// One request outstanding at a time; addr_ok accepts, data_ok returns the word.
// The master holds valid/addr stable until addr_ok is seen.

interface fetch_if;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;

  modport master (
    output ireq_valid, ireq_addr,
    input  iresp_addr_ok, iresp_data_ok, iresp_data
  );

  modport slave (
    input  ireq_valid, ireq_addr,
    output iresp_addr_ok, iresp_data_ok, iresp_data
  );
endinterface

// File: rtl/fetch.sv
// Fetch stage: issues one instruction-bus request at a time and registers the word into dataF.
// Latency: data_ok -> dataF.valid one cycle; addr_ok+data_ok together act as accept-then-return.
// Backpressure: stall holds dataF and blocks new requests unless an unaccepted request is pending.

module fetch
  import pipes::*;
#(
  parameter logic [63:0] PC_RESET = common::PC_RESET
) (
  input  logic        clk,
  input  logic        reset,
  fetch_if.master     ibus,
  input  logic        stall,
  input  logic        jump,
  input  logic [63:0] pcsrc,
  output fetch_data_t dataF
);

  typedef enum logic {S_REQ, S_WAIT} state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] req_pc_q, req_pc_d;
  logic [63:0] redir_pc_q, redir_pc_d;
  logic        discard_q, discard_d;
  logic        sticky_q, sticky_d;
  logic        redir_pend_q, redir_pend_d;
  fetch_data_t data_q, data_d;

  common::ibus_req_t  ireq;
  common::ibus_resp_t iresp;

  logic        consume;
  logic        redirect;
  logic        drop;
  logic        fill;
  logic [63:0] fill_pc;

  assign iresp = {ibus.iresp_addr_ok, ibus.iresp_data_ok, ibus.iresp_data};

  assign consume  = data_q.valid & ~stall;
  assign redirect = consume & jump;

  // A request goes out when dataF has room, or to keep an unaccepted request on the bus.
  assign ireq.valid = (state_q == S_REQ) & (~data_q.valid | consume | sticky_q);
  assign ireq.addr  = pc_q;

  assign ibus.ireq_valid = ireq.valid;
  assign ibus.ireq_addr  = ireq.addr;
  assign dataF           = data_q;

  // Next-state: request/response sequencing, redirect bookkeeping and dataF update.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    redir_pc_d   = redir_pc_q;
    discard_d    = discard_q;
    sticky_d     = sticky_q;
    redir_pend_d = redir_pend_q;
    data_d       = data_q;
    drop         = 1'b0;
    fill         = 1'b0;
    fill_pc      = req_pc_q;

    if (consume) data_d.valid = 1'b0;

    case (state_q)
      S_REQ: begin
        if (ireq.valid) begin
          if (iresp.addr_ok) begin
            sticky_d     = 1'b0;
            redir_pend_d = 1'b0;
            req_pc_d     = pc_q;
            // The accepted address is wrong-path if a redirect arrived now or while it waited.
            drop = redirect | redir_pend_q;
            if (redirect)          pc_d = pcsrc;
            else if (redir_pend_q) pc_d = redir_pc_q;
            else                   pc_d = pc_q + 64'd4;
            if (iresp.data_ok) begin
              fill      = ~drop;
              fill_pc   = pc_q;
              discard_d = 1'b0;
            end else begin
              state_d   = S_WAIT;
              discard_d = drop;
            end
          end else begin
            // Address must stay put until accepted, so park the redirect target.
            sticky_d = 1'b1;
            if (redirect) begin
              redir_pend_d = 1'b1;
              redir_pc_d   = pcsrc;
            end
          end
        end
      end
      S_WAIT: begin
        if (redirect) pc_d = pcsrc;
        if (iresp.data_ok) begin
          state_d   = S_REQ;
          discard_d = 1'b0;
          fill      = ~discard_q & ~redirect;
        end else if (redirect) begin
          discard_d = 1'b1;
        end
      end
      default: state_d = S_REQ;
    endcase

    if (fill) begin
      data_d.valid     = 1'b1;
      data_d.pc        = fill_pc;
      data_d.raw_instr = iresp.data;
    end
  end

  // State registers; reset abandons any outstanding request outright.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_REQ;
      pc_q         <= PC_RESET;
      req_pc_q     <= '0;
      redir_pc_q   <= '0;
      discard_q    <= 1'b0;
      sticky_q     <= 1'b0;
      redir_pend_q <= 1'b0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      redir_pc_q   <= redir_pc_d;
      discard_q    <= discard_d;
      sticky_q     <= sticky_d;
      redir_pend_q <= redir_pend_d;
      data_q       <= data_d;
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Directed bench for the fetch stage: hand-computed expectations checked each cycle.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// Ends with a single summary line.

module tb_fetch;
  import pipes::*;

  localparam logic [63:0] PC_RST = 64'h0000_0000_8000_0000;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        jump;
  logic [63:0] pcsrc;
  fetch_data_t dataF;

  int n_tests;
  int n_fail;

  fetch_if ibus ();

  fetch #(.PC_RESET(PC_RST)) dut (
    .clk   (clk),
    .reset (reset),
    .ibus  (ibus.master),
    .stall (stall),
    .jump  (jump),
    .pcsrc (pcsrc),
    .dataF (dataF)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic ao, input logic dok, input logic [31:0] d,
                       input logic st, input logic jp, input logic [63:0] tgt);
    ibus.iresp_addr_ok = ao;
    ibus.iresp_data_ok = dok;
    ibus.iresp_data    = d;
    stall              = st;
    jump               = jp;
    pcsrc              = tgt;
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic fetch_data_t mk(input logic v, input logic [63:0] p, input logic [31:0] r);
    fetch_data_t f;
    f.valid     = v;
    f.pc        = p;
    f.raw_instr = r;
    return f;
  endfunction

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    tick();

    // Reset values and first request after reset; accept immediately.
    reset = 1'b0;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    check("rst_dataF", dataF, '0);
    check("rst_req_vld", ibus.ireq_valid, 1'b1);
    check("rst_req_addr", ibus.ireq_addr, PC_RST);
    tick();

    // Waiting: data returns one cycle after acceptance.
    drive(1'b0, 1'b1, 32'h0000_0513, 1'b0, 1'b0, 64'h0);
    check("wait_no_req", ibus.ireq_valid, 1'b0);
    check("no_early_fill", dataF.valid, 1'b0);
    tick();

    // Four stalled cycles with jump asserted: dataF held, jump ignored, no request.
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 64'hDEAD_0000);
      check("stall_hold", dataF, mk(1'b1, PC_RST, 32'h0000_0513));
      check("stall_no_req", ibus.ireq_valid, 1'b0);
      check("next_addr", ibus.ireq_addr, PC_RST + 64'd4);
      tick();
    end

    // Stall drops with a redirect while the bus refuses the request.
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 64'h0000_0000_8000_0200);
    check("unstall_req_vld", ibus.ireq_valid, 1'b1);
    check("unstall_req_addr", ibus.ireq_addr, PC_RST + 64'd4);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
      check("redir_clears_vld", dataF.valid, 1'b0);
      check("sticky_vld", ibus.ireq_valid, 1'b1);
      check("sticky_addr", ibus.ireq_addr, PC_RST + 64'd4);
      tick();
    end
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    check("sticky_addr_acc", ibus.ireq_addr, PC_RST + 64'd4);
    tick();
    drive(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 64'h0);
    check("discard_wait", ibus.ireq_valid, 1'b0);
    tick();

    // Wrong-path word dropped, fetch resumes at the stored redirect target.
    drive(1'b1, 1'b1, 32'h0000_0011, 1'b0, 1'b0, 64'h0);
    check("discard_drop", dataF.valid, 1'b0);
    check("redir_addr", ibus.ireq_addr, 64'h0000_0000_8000_0200);
    tick();

    // Redirect coinciding with a combined addr_ok/data_ok response drops that data.
    drive(1'b1, 1'b1, 32'h0000_0022, 1'b0, 1'b1, 64'h0000_0000_8000_0100);
    check("combo_fill", dataF, mk(1'b1, 64'h0000_0000_8000_0200, 32'h0000_0011));
    check("combo_next_addr", ibus.ireq_addr, 64'h0000_0000_8000_0204);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    check("redir_data_drop", dataF.valid, 1'b0);
    check("redir2_vld", ibus.ireq_valid, 1'b1);
    check("redir2_addr", ibus.ireq_addr, 64'h0000_0000_8000_0100);
    tick();
    drive(1'b0, 1'b1, 32'h0000_0033, 1'b0, 1'b0, 64'h0);
    tick();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    check("redir_target_fill", dataF, mk(1'b1, 64'h0000_0000_8000_0100, 32'h0000_0033));
    tick();

    // Reset while waiting; late data_ok after reset is ignored.
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    tick();
    reset = 1'b0;
    drive(1'b0, 1'b1, 32'h0000_0BAD, 1'b0, 1'b0, 64'h0);
    check("rst2_dataF", dataF, '0);
    check("rst2_req_vld", ibus.ireq_valid, 1'b1);
    check("rst2_req_addr", ibus.ireq_addr, PC_RST);
    tick();
    drive(1'b1, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 64'h0);
    check("late_data_ignored", dataF.valid, 1'b0);
    check("restart_addr", ibus.ireq_addr, PC_RST);
    tick();

    // Back-to-back responses: a new word every cycle.
    for (int i = 0; i < 3; i++) begin
      if (i < 2) drive(1'b1, 1'b1, 32'h0000_0104 + 32'(4 * i), 1'b0, 1'b0, 64'h0);
      else       drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
      check("b2b_dataF", dataF, mk(1'b1, PC_RST + 64'(4 * i), 32'h0000_0100 + 32'(4 * i)));
      tick();
    end

    // Redirect on addr_ok enters wait with discard; then 64-bit PC wrap.
    drive(1'b0, 1'b1, 32'h0000_0099, 1'b0, 1'b0, 64'h0);
    check("acc_redir_vld", dataF.valid, 1'b0);
    check("acc_redir_wait", ibus.ireq_valid, 1'b0);
    tick();
    drive(1'b1, 1'b1, 32'h0000_0077, 1'b0, 1'b0, 64'h0);
    check("acc_redir_drop", dataF.valid, 1'b0);
    check("wrap_req_addr", ibus.ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 64'h0000_0000_0000_1234);
    check("wrap_fill", dataF, mk(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0000_0077));
    check("wrap_addr", ibus.ireq_addr, 64'h0);
    check("wrap_stall_vld", ibus.ireq_valid, 1'b0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    check("stalled_jump_ignored", dataF, mk(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0000_0077));
    check("resume_vld", ibus.ireq_valid, 1'b1);
    check("resume_addr", ibus.ireq_addr, 64'h0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
